ocport_ctrl: RTL and testbench

Parametrised multi-port open/close controller, successor to the single-port OCPort. Each of `NUM_PORTS` ports is toggled open or closed by flipping its switch. Each port models a finite travel time. An optional airlock interlock permits at most one non-closed port at a time. The block sits between the board switches and the port status LEDs/actuator drivers.

---
 rtl/ocport_pkg.sv | 14 +
 rtl/ocport_if.sv | 13 +
 rtl/ocport_channel.sv | 132 +++++++++++++
 rtl/ocport_ctrl.sv | 58 +++++
 tb/tb_ocport_ctrl.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ocport_pkg.sv
// Shared types and default constants for the multi-port open/close controller.
package ocport_pkg;

  typedef enum logic [1:0] {
    CLOSED  = 2'b00,
    OPENING = 2'b01,
    OPEN    = 2'b10,
    CLOSING = 2'b11
  } port_state_t;

  localparam int unsigned TRAVEL_CYCLES_DEF   = 4;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 3;

endpackage

// File: rtl/ocport_if.sv
// Switch inputs and status outputs of the port controller, one bit per port.
interface ocport_if #(
  parameter int unsigned NUM_PORTS = 2
);
  logic [NUM_PORTS-1:0] SwitchFlip;
  logic [NUM_PORTS-1:0] Open;
  logic [NUM_PORTS-1:0] Closed;
  logic [NUM_PORTS-1:0] Moving;
  logic [NUM_PORTS-1:0] Blocked;

  modport master (output SwitchFlip, input Open, Closed, Moving, Blocked);
  modport slave  (input SwitchFlip, output Open, Closed, Moving, Blocked);
endinterface

// File: rtl/ocport_channel.sv
// One port: synchronizer, optional debounce (OCPORT_DEBOUNCE_EN), edge detect,
// travel FSM and counter. Status outputs are registered from the next state.
module ocport_channel
  import ocport_pkg::*;
#(
  parameter int unsigned TRAVEL_CYCLES   = TRAVEL_CYCLES_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic switch_raw,
  input  logic grant,
  output logic req_open,
  output logic is_open,
  output logic is_closed,
  output logic is_moving,
  output logic blocked
);

  localparam int unsigned   CW      = $clog2(TRAVEL_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(TRAVEL_CYCLES - 1);

  if (TRAVEL_CYCLES == 0 || DEBOUNCE_CYCLES == 0) begin : g_bad_param
    $error("ocport_channel: TRAVEL_CYCLES and DEBOUNCE_CYCLES must be at least 1");
  end

  logic          sync1, sync2, level, level_d, req;
  logic [CW-1:0] cnt, cnt_nxt;
  port_state_t   state, state_nxt;

  // Two-flop synchronizer for the asynchronous switch level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= switch_raw;
      sync2 <= sync1;
    end
  end

`ifdef OCPORT_DEBOUNCE_EN
  localparam int unsigned   DW     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_TOP = DW'(DEBOUNCE_CYCLES - 1);

  logic [DW-1:0] db_cnt;

  // Adopt the synchronized level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= 1'b0;
      db_cnt <= '0;
    end else if (sync2 == level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_TOP) begin
      level  <= sync2;
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + DW'(1);
    end
  end
`else
  assign level = sync2;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign req      = level ^ level_d;
  assign req_open = req && (state == CLOSED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= CLOSED;
      cnt       <= '0;
      is_open   <= 1'b0;
      is_closed <= 1'b1;
      is_moving <= 1'b0;
      blocked   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      is_open   <= (state_nxt == OPEN);
      is_closed <= (state_nxt == CLOSED);
      is_moving <= (state_nxt == OPENING) || (state_nxt == CLOSING);
      blocked   <= req_open && !grant;
    end
  end

  // A reversal keeps the travel already done as the travel still to do
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      CLOSED: begin
        if (req_open && grant) begin
          state_nxt = OPENING;
          cnt_nxt   = CNT_TOP;
        end
      end
      OPENING: begin
        if (req) begin
          state_nxt = CLOSING;
          cnt_nxt   = CNT_TOP - cnt;
        end else if (cnt == '0) begin
          state_nxt = OPEN;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      OPEN: begin
        if (req) begin
          state_nxt = CLOSING;
          cnt_nxt   = CNT_TOP;
        end
      end
      CLOSING: begin
        if (req) begin
          state_nxt = OPENING;
          cnt_nxt   = CNT_TOP - cnt;
        end else if (cnt == '0) begin
          state_nxt = CLOSED;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/ocport_ctrl.sv
// Multi-port open/close controller with optional airlock interlock.
// Define OCPORT_DEBOUNCE_EN to add a switch debounce filter in every port.
module ocport_ctrl
  import ocport_pkg::*;
#(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned TRAVEL_CYCLES   = TRAVEL_CYCLES_DEF,
  parameter int unsigned INTERLOCK       = 1,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input logic     Clock,
  input logic     Reset,
  ocport_if.slave bus
);

  logic [NUM_PORTS-1:0] req_open, grant;
  logic [NUM_PORTS-1:0] open_q, closed_q, moving_q, blocked_q;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    ocport_channel #(
      .TRAVEL_CYCLES  (TRAVEL_CYCLES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk       (Clock),
      .rst       (Reset),
      .switch_raw(bus.SwitchFlip[i]),
      .grant     (grant[i]),
      .req_open  (req_open[i]),
      .is_open   (open_q[i]),
      .is_closed (closed_q[i]),
      .is_moving (moving_q[i]),
      .blocked   (blocked_q[i])
    );
  end

  if (INTERLOCK != 0) begin : g_lock
    // Fixed priority: lowest index wins, and only when every other port is closed
    always_comb begin
      logic taken;
      taken = 1'b0;
      grant = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (req_open[i] && !taken && (&(closed_q | (NUM_PORTS'(1) << i)))) begin
          grant[i] = 1'b1;
          taken    = 1'b1;
        end
      end
    end
  end else begin : g_free
    assign grant = req_open;
  end

  assign bus.Open    = open_q;
  assign bus.Closed  = closed_q;
  assign bus.Moving  = moving_q;
  assign bus.Blocked = blocked_q;

endmodule

// File: tb/tb_ocport_ctrl.sv
// Self-checking bench for ocport_ctrl: interlocked and free-running instances
// share the same switches and are compared every cycle against a position model.
module tb_ocport_ctrl;
  import ocport_pkg::*;

  localparam int unsigned NP = 2;
  localparam int unsigned TC = 4;
  localparam int unsigned DC = 3;
  localparam int unsigned HL = DC + 3;
`ifdef OCPORT_DEBOUNCE_EN
  localparam int unsigned LAT    = 3 + DC;
  localparam int unsigned REV_MV = 0;
`else
  localparam int unsigned LAT    = 3;
  localparam int unsigned REV_MV = 4;
`endif

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic [NP-1:0] sw = '0;

  always #5 Clock = ~Clock;

  ocport_if #(.NUM_PORTS(NP)) bus_lock ();
  ocport_if #(.NUM_PORTS(NP)) bus_free ();

  assign bus_lock.SwitchFlip = sw;
  assign bus_free.SwitchFlip = sw;

  ocport_ctrl #(.NUM_PORTS(NP), .TRAVEL_CYCLES(TC), .INTERLOCK(1), .DEBOUNCE_CYCLES(DC))
    dut_lock (.Clock(Clock), .Reset(Reset), .bus(bus_lock));
  ocport_ctrl #(.NUM_PORTS(NP), .TRAVEL_CYCLES(TC), .INTERLOCK(0), .DEBOUNCE_CYCLES(DC))
    dut_free (.Clock(Clock), .Reset(Reset), .bus(bus_free));

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  // Model: pos = travel done toward open (0..TC), dir = +1 opening, -1 closing, 0 at rest
  int   pos     [2][NP];
  int   dir     [2][NP];
  logic blk_exp [2][NP];
  logic hist    [NP][HL];
`ifdef OCPORT_DEBOUNCE_EN
  logic filt    [NP];
  logic filt_d  [NP];
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NP; i++) begin
        pos[k][i]     = 0;
        dir[k][i]     = 0;
        blk_exp[k][i] = 1'b0;
      end
    for (int i = 0; i < NP; i++) begin
      for (int j = 0; j < HL; j++) hist[i][j] = 1'b0;
`ifdef OCPORT_DEBOUNCE_EN
      filt[i]   = 1'b0;
      filt_d[i] = 1'b0;
`endif
    end
  endtask

  task automatic model_edge();
    logic req [NP];
    logic closed_snap [NP];
    logic taken, ok;
    for (int i = 0; i < NP; i++) begin
`ifdef OCPORT_DEBOUNCE_EN
      req[i] = filt[i] ^ filt_d[i];
      ok = 1'b1;
      for (int j = 1; j <= DC; j++) if (hist[i][j] == filt[i]) ok = 1'b0;
      filt_d[i] = filt[i];
      if (ok) filt[i] = ~filt[i];
`else
      // A switch sampled at edge n becomes a request at edge n+2
      req[i] = hist[i][1] ^ hist[i][2];
`endif
      for (int j = HL - 1; j > 0; j--) hist[i][j] = hist[i][j-1];
      hist[i][0] = sw[i];
    end
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) closed_snap[i] = (dir[k][i] == 0) && (pos[k][i] == 0);
      taken = 1'b0;
      for (int i = 0; i < NP; i++) begin
        blk_exp[k][i] = 1'b0;
        if (dir[k][i] != 0) begin
          pos[k][i] += dir[k][i];
          if (req[i]) dir[k][i] = -dir[k][i];
          else if (pos[k][i] == 0 || pos[k][i] == int'(TC)) dir[k][i] = 0;
        end else if (pos[k][i] == int'(TC)) begin
          if (req[i]) dir[k][i] = -1;
        end else if (req[i]) begin
          ok = 1'b1;
          if (k == 0) begin
            if (taken) ok = 1'b0;
            for (int j = 0; j < NP; j++) if (j != i && !closed_snap[j]) ok = 1'b0;
          end
          if (ok) begin
            dir[k][i] = 1;
            taken = 1'b1;
          end else begin
            blk_exp[k][i] = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    logic [NP-1:0] eo, ec, em, eb;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < NP; i++) begin
        eo[i] = (dir[k][i] == 0) && (pos[k][i] == int'(TC));
        ec[i] = (dir[k][i] == 0) && (pos[k][i] == 0);
        em[i] = (dir[k][i] != 0);
        eb[i] = blk_exp[k][i];
      end
      if (k == 0) begin
        check_eq("lock Open",    32'(bus_lock.Open),    32'(eo));
        check_eq("lock Closed",  32'(bus_lock.Closed),  32'(ec));
        check_eq("lock Moving",  32'(bus_lock.Moving),  32'(em));
        check_eq("lock Blocked", 32'(bus_lock.Blocked), 32'(eb));
      end else begin
        check_eq("free Open",    32'(bus_free.Open),    32'(eo));
        check_eq("free Closed",  32'(bus_free.Closed),  32'(ec));
        check_eq("free Moving",  32'(bus_free.Moving),  32'(em));
        check_eq("free Blocked", 32'(bus_free.Blocked), 32'(eb));
      end
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    cyc++;
    if (!Reset) model_edge();
    @(negedge Clock);
    check_outputs();
  endtask

  task automatic run(input int unsigned n);
    repeat (n) tick();
  endtask

  task automatic toggle(input int unsigned p);
    sw[p] = ~sw[p];
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    sw    = '0;
    model_reset();
    repeat (2) @(negedge Clock);
    Reset = 1'b0;
    check_outputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    int unsigned first, mv, nb, seen;

    model_reset();
    do_reset();
    check_eq("reset Closed", 32'(bus_lock.Closed), 32'h3);
    check_eq("reset Moving", 32'(bus_lock.Moving), 32'h0);

    // Open port 0, then close it
    toggle(0);
    first = 0; mv = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (bus_lock.Moving[0]) begin
        mv++;
        if (first == 0) first = t;
      end
    end
    check_eq("open latency", 32'(first), 32'(LAT));
    check_eq("open travel", 32'(mv), 32'(TC));
    check_eq("port0 open", 32'(bus_lock.Open[0]), 32'h1);
    toggle(0);
    mv = 0;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (bus_lock.Moving[0]) mv++;
    end
    check_eq("close travel", 32'(mv), 32'(TC));
    check_eq("port0 closed", 32'(bus_lock.Closed[0]), 32'h1);

    // Interlock refusal while port 0 is open, then normal open once it closes
    toggle(0);
    run(16);
    toggle(1);
    nb = 0; seen = 1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (bus_lock.Blocked[1]) nb++;
      if (!bus_lock.Closed[1]) seen = 0;
    end
    check_eq("blocked pulses", 32'(nb), 32'h1);
    check_eq("port1 held closed", 32'(seen), 32'h1);
    toggle(0);
    run(16);
    toggle(1);
    run(16);
    check_eq("port1 opens later", 32'(bus_lock.Open[1]), 32'h1);

    // Simultaneous requests from all-closed
    do_reset();
    toggle(0);
    toggle(1);
    run(LAT);
    check_eq("same-cycle lock Moving", 32'(bus_lock.Moving), 32'h1);
    check_eq("same-cycle lock Blocked", 32'(bus_lock.Blocked), 32'h2);
    check_eq("same-cycle free Moving", 32'(bus_free.Moving), 32'h3);
    run(16);

    // Two toggles two cycles apart: reversal mid-travel (filtered away with debounce)
    do_reset();
    toggle(0);
    run(2);
    toggle(0);
    mv = 0; seen = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      if (bus_lock.Moving[0]) mv++;
      if (bus_lock.Open[0]) seen = 1;
    end
    check_eq("reversal travel", 32'(mv), 32'(REV_MV));
    check_eq("reversal never open", 32'(seen), 32'h0);
    check_eq("reversal closed", 32'(bus_lock.Closed[0]), 32'h1);

    // Asynchronous reset in the middle of OPENING
    toggle(0);
    run(LAT + 1);
    check_eq("pre-reset moving", 32'(bus_lock.Moving[0]), 32'h1);
    #2 Reset = 1'b1;
    model_reset();
    #1;
    check_outputs();
    check_eq("async reset Closed", 32'(bus_lock.Closed), 32'h3);
    @(negedge Clock);
    Reset = 1'b0;
    run(16);

    // Random switch activity
    for (int t = 0; t < 400; t++) begin
      if ($urandom_range(0, 3) == 0) sw = sw ^ NP'($urandom_range(1, 3));
      tick();
    end
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
